// File: rtl/viterbi_pkg.sv
// Shared widths, FSM states and signed data types for the Viterbi branch-metric controller.
package viterbi_pkg;

    localparam int SYM_W   = 8;
    localparam int BM_W    = 9;
    localparam int NUM_HYP = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef logic signed [SYM_W-1:0] sym_t;
    typedef logic signed [BM_W-1:0]  metric_t;

    // Widen one scaled symbol to metric width, keeping its sign.
    function automatic metric_t sext_sym(input sym_t s);
        return {s[SYM_W-1], s};
    endfunction

endpackage

// File: rtl/viterbi_bm_ctrl_bm_scale.sv
// Shared soft-symbol scaler: multiplies by +2 or -2 and wraps to the symbol width.
module bm_scale
    import viterbi_pkg::*;
(
    input  logic signed [SYM_W-1:0] a,
    input  logic                    neg,
    output logic signed [SYM_W-1:0] y
);

    sym_t dbl;

    // Dropping the top bit of a*2 and negating within SYM_W gives plain
    // two's-complement wrap-around; no saturation is wanted here.
    assign dbl = {a[SYM_W-2:0], 1'b0};
    assign y   = neg ? sym_t'(-dbl) : dbl;

endmodule

// File: rtl/viterbi_bm_ctrl.sv
// Serial branch-metric generator: one scaled symbol per cycle, four metrics per symbol pair.
module viterbi_bm_ctrl
    import viterbi_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic signed [SYM_W-1:0] r0,
    input  logic signed [SYM_W-1:0] r1,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic signed [BM_W-1:0] bm0,
    output logic signed [BM_W-1:0] bm1,
    output logic signed [BM_W-1:0] bm2,
    output logic signed [BM_W-1:0] bm3,
    output logic                   busy
);

    state_e       state_q;
    logic [2:0]   step_q;
    metric_t      acc_q;
    sym_t         r0_q;
    sym_t         r1_q;
    metric_t      bm_q [NUM_HYP];
    logic         in_ready_q;
    logic         out_valid_q;
    logic         busy_q;

    sym_t         sym_sel;
    logic         neg_sel;
    sym_t         prod;
    metric_t      sum_d;

    // step[0] picks the symbol; the matching hypothesis bit (b0 for r0, b1 for r1) picks the sign.
    assign sym_sel = step_q[0] ? r1_q : r0_q;
    assign neg_sel = step_q[0] ? step_q[2] : step_q[1];

    bm_scale u_bm_scale (
        .a   (sym_sel),
        .neg (neg_sel),
        .y   (prod)
    );

    assign sum_d = acc_q + sext_sym(prod);

    // NOTE: all state is updated with non-blocking assignments so every
    // register samples pre-edge values and ordering inside the block is irrelevant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            step_q      <= '0;
            acc_q       <= '0;
            r0_q        <= '0;
            r1_q        <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            // NOTE: the metric bank is only four registers and must read zero
            // after reset, so it is reset like ordinary flops, not left as RAM.
            for (int i = 0; i < NUM_HYP; i++) begin
                bm_q[i] <= '0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        r0_q       <= r0;
                        r1_q       <= r1;
                        step_q     <= '0;
                        acc_q      <= '0;
                        state_q    <= ST_RUN;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (step_q[0]) begin
                        bm_q[step_q[2:1]] <= sum_d;
                        acc_q             <= '0;
                    end else begin
                        acc_q <= sum_d;
                    end
                    step_q <= step_q + 3'd1;
                    if (step_q == 3'd7) begin
                        state_q     <= ST_DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign bm0       = bm_q[0];
    assign bm1       = bm_q[1];
    assign bm2       = bm_q[2];
    assign bm3       = bm_q[3];

endmodule

// File: doc/viterbi_bm_ctrl.md
VITERBI_BM_CTRL -- requirements
Module: viterbi_bm_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports listed as follows.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  a received symbol pair is present on r0/r1.
REQ-005 in_ready  output  1  block can accept a symbol pair.
REQ-006 r0  input  8  signed soft symbol for code bit 0.
REQ-007 r1  input  8  signed soft symbol for code bit 1.
REQ-008 out_valid  output  1  bm0..bm3 hold a complete metric set.
REQ-009 out_ready  input  1  consumer accepts the metric set.
REQ-010 bm0, bm1, bm2, bm3  output  9 each  signed branch metrics for hypotheses {b1,b0} = 00, 01, 10, 11.
REQ-011 busy  output  1  high in RUN or DONE.

Function
REQ-012 The FSM SHALL have the states IDLE, RUN and DONE.
REQ-013 in_ready SHALL be 1 only in IDLE.
REQ-014 In IDLE, on a clock edge with in_valid=1, the block SHALL register r0 and r1, clear step, clear the accumulator and enter RUN.
REQ-015 In RUN, a 3-bit step counter SHALL select the hypothesis from step[2:1] and the symbol from step[0] (0 selects r0, 1 selects r1).
REQ-016 In RUN, one shared scaler SHALL be used once per cycle.
  - Bit value 0 selects x2; bit value 1 selects x(-2).
  - Example: step 5 selects hypothesis 10 and r1, so b1=1 and the scaler applies x(-2) to r1.
REQ-017 Scaler output SHALL be the 8-bit signed wrap-around result (two's-complement truncation); it SHALL NOT saturate.
REQ-018 The accumulator SHALL sign-extend each 8-bit product to 9 bits and add it; overflow of the 9-bit sum is impossible.
REQ-019 On odd steps the completed sum SHALL be written to bm[step[2:1]], and the accumulator SHALL restart at the next even step.
REQ-020 Timing SHALL be as follows.
  - Handshake at edge T.
  - Steps 0..7 execute on edges T+1..T+8.
  - On edge T+8 the state becomes DONE and out_valid=1.
  - Latency is 8 cycles from input acceptance to out_valid.
REQ-021 In DONE, out_valid and bm0..bm3 SHALL hold stable until out_ready=1.
REQ-022 On the out_valid and out_ready edge, the FSM SHALL return to IDLE, out_valid SHALL be 0, and bm0..bm3 SHALL retain their values.
REQ-023 In RUN and DONE, in_valid SHALL be ignored; no input is captured and r0/r1 changes have no effect.
REQ-024 Maximum throughput SHALL be one symbol pair per 10 cycles, with out_ready held high.
REQ-025 No combinational path SHALL exist from any input to any output.

Reset
REQ-026 Asserting rst_n=0 at any time, including mid-RUN or in DONE, SHALL immediately force the following: state=IDLE, in_ready=1, out_valid=0, busy=0, step=0, accumulator=0, bm0..bm3=0, captured r0/r1=0.
REQ-027 After rst_n deassertion, the first in_valid SHALL be accepted normally; a partial computation SHALL NOT be resumed.

Structure
REQ-028 Package viterbi_pkg SHALL hold the following:
  - SYM_W=8, BM_W=9, NUM_HYP=4;
  - the FSM state enumeration;
  - a signed symbol typedef and a signed metric typedef.
REQ-029 One sub-module, bm_scale, SHALL be instantiated exactly once.
  - Combinational; inputs: 8-bit signed a, 1-bit neg.
  - Output: 8-bit wrapped a*2 when neg=0, a*(-2) when neg=1.

Verification
REQ-030 r0=10, r1=-3, out_ready=1 -> out_valid rises 8 cycles after acceptance with bm0=14, bm1=-26, bm2=26, bm3=-14; then in_ready=1 the next cycle.
REQ-031 Wrap-around: r0=100, r1=0 -> bm0=-56, bm1=56, bm2=-56, bm3=56; r0=-128, r1=-128 -> all four metrics 0.
REQ-032 Backpressure: out_ready=0 for 5 cycles after out_valid, with r0/r1 and in_valid toggling -> outputs stable, in_ready=0, no capture; out_ready=1 -> IDLE on the next edge.
REQ-033 Reset mid-RUN: assert rst_n=0 at step 3 -> all outputs at reset values immediately; after release, r0=1, r1=1 -> bm0=4, bm1=0, bm2=0, bm3=-4.
REQ-034 Back-to-back: two symbol pairs, with in_valid and out_ready held high -> second acceptance occurs exactly 10 cycles after the first; both metric sets are correct.
